// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/halt/step sequencer.
// The 2-bit state encodings are also used by the seg7 display mux.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_BRK  = 2'b11
    } run_state_t;

    // Synchroniser depth used for every asynchronous input of the sequencer.
    localparam int SYNC_STAGES = 2;

endpackage : cpu_run_ctrl_pkg

// File: rtl/cpu_run_ctrl_if.sv
// CPU-side bus of the run controller: PC/breakpoint inputs, clock enable,
// state, breakpoint flag and retired-instruction count.
// master = the controller, slave = the CPU / observer side.
interface cpu_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic [PC_W-1:0]  pc;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic             cpu_ce;
    logic [1:0]       state_o;
    logic             bp_hit_o;
    logic [CNT_W-1:0] retired_o;

    modport master (
        input  pc, bp_en, bp_addr,
        output cpu_ce, state_o, bp_hit_o, retired_o
    );

    modport slave (
        output pc, bp_en, bp_addr,
        input  cpu_ce, state_o, bp_hit_o, retired_o
    );
endinterface : cpu_run_ctrl_if

// File: rtl/cpu_run_ctrl_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level counter and a
// one-clk press pulse on each accepted rising level. A held button gives
// exactly one press; glitches shorter than 2^DEB_LOG2 clk are rejected.
module btn_debounce #(
    parameter int DEB_LOG2 = 20
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_btn,
    output logic o_press
);
    logic                r_meta;
    logic                r_sync;
    logic                r_level;
    logic [DEB_LOG2-1:0] r_cnt;
    logic                r_press;

    // Synchronise, then accept a new level only after it has differed from
    // the accepted level for 2^DEB_LOG2 consecutive clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                r_level <= r_sync;
                r_cnt   <= '0;
                r_press <= r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule : btn_debounce

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer producing a one-clk CPU clock enable.
// Optional PC breakpoint: define CPU_RUN_CTRL_BREAKPOINT_EN to enable it.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W           = 32,
    parameter int CNT_W          = 32,
    parameter int TICK_FAST_LOG2 = 3,
    parameter int TICK_SLOW_LOG2 = 27,
    parameter int DEB_LOG2       = 20
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          slow_sel,
    input  logic          btn_run,
    input  logic          btn_step,
    cpu_run_ctrl_if.master bus
);
    localparam logic [TICK_SLOW_LOG2-1:0] FAST_MASK =
        TICK_SLOW_LOG2'((1 << TICK_FAST_LOG2) - 1);

    logic [SYNC_STAGES-1:0]    r_slow_sync;
    logic [TICK_SLOW_LOG2-1:0] r_tick_cnt;
    logic [TICK_SLOW_LOG2-1:0] w_tick_mask;
    logic                      w_tick;
    logic                      w_run_press;
    logic                      w_step_press;
    logic                      w_bp_trap;
    run_state_t                r_state;
    logic                      r_cpu_ce;
    logic [CNT_W-1:0]          r_retired;

    // Bring the rate switch into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_slow_sync <= '0;
        else       r_slow_sync <= {r_slow_sync[SYNC_STAGES-2:0], slow_sel};
    end

    // Free-running tick counter; the rate switch only changes the compare mask.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_tick_cnt <= '0;
        else       r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    assign w_tick_mask = r_slow_sync[SYNC_STAGES-1] ? '1 : FAST_MASK;
    assign w_tick      = ((r_tick_cnt & w_tick_mask) == w_tick_mask);

    btn_debounce #(.DEB_LOG2(DEB_LOG2)) u_deb_run (
        .clk     (clk),
        .rstn    (rstn),
        .i_btn   (btn_run),
        .o_press (w_run_press)
    );

    btn_debounce #(.DEB_LOG2(DEB_LOG2)) u_deb_step (
        .clk     (clk),
        .rstn    (rstn),
        .i_btn   (btn_step),
        .o_press (w_step_press)
    );

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic r_skip;

    // Skip lets the trapped instruction retire once after resuming.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_skip <= 1'b0;
        else if (r_state == ST_BRK && (w_run_press || w_step_press))
            r_skip <= 1'b1;
        else if (r_cpu_ce)
            r_skip <= 1'b0;
    end

    assign w_bp_trap    = bus.bp_en && (bus.pc == bus.bp_addr) && !r_skip;
    assign bus.bp_hit_o = (r_state == ST_BRK);
`else
    logic w_bp_unused;
    assign w_bp_unused  = ^{bus.pc, bus.bp_en, bus.bp_addr};
    assign w_bp_trap    = 1'b0;
    assign bus.bp_hit_o = 1'b0;
`endif

    // Sequencer FSM; cpu_ce is registered from the tick seen in this state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_HALT;
            r_cpu_ce <= 1'b0;
        end else begin
            r_cpu_ce <= 1'b0;
            case (r_state)
                ST_HALT: begin
                    if (w_run_press)       r_state <= ST_RUN;
                    else if (w_step_press) r_state <= ST_STEP;
                end
                ST_RUN: begin
                    if (w_run_press) begin
                        r_state <= ST_HALT;
                    end else if (w_tick) begin
                        if (w_bp_trap) r_state  <= ST_BRK;
                        else           r_cpu_ce <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (w_run_press) begin
                        r_state <= ST_RUN;
                    end else if (w_tick) begin
                        if (w_bp_trap) begin
                            r_state <= ST_BRK;
                        end else begin
                            r_cpu_ce <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                    end
                end
                ST_BRK: begin
                    if (w_run_press)       r_state <= ST_RUN;
                    else if (w_step_press) r_state <= ST_STEP;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         r_retired <= '0;
        else if (r_cpu_ce) r_retired <= r_retired + 1'b1;
    end

    assign bus.cpu_ce    = r_cpu_ce;
    assign bus.state_o   = r_state;
    assign bus.retired_o = r_retired;

endmodule : cpu_run_ctrl

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with short tick/debounce periods.
// Breakpoint scenario is built when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic slow_sel = 1'b0;
    logic btn_run = 1'b0;
    logic btn_step = 1'b0;
    logic pc_load = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    // Monitor state
    int ce_total = 0;
    int consec_err = 0;
    int cyc = 0;
    int last_ce_cyc = 0;
    int last_gap = 0;
    logic prev_ce = 1'b0;

    cpu_run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus_if ();

    cpu_run_ctrl #(
        .PC_W           (32),
        .CNT_W          (32),
        .TICK_FAST_LOG2 (2),
        .TICK_SLOW_LOG2 (4),
        .DEB_LOG2       (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .slow_sel (slow_sel),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // CPU PC model: advances by 4 on every enabled clk edge.
    always @(posedge clk) begin
        if (pc_load)            bus_if.pc <= 32'h0;
        else if (bus_if.cpu_ce) bus_if.pc <= bus_if.pc + 32'd4;
    end

    // Enable pulse monitor: total count, spacing, back-to-back detection.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus_if.cpu_ce === 1'b1) begin
            ce_total = ce_total + 1;
            if (prev_ce === 1'b1) consec_err = consec_err + 1;
            last_gap = cyc - last_ce_cyc;
            last_ce_cyc = cyc;
        end
        prev_ce = bus_if.cpu_ce;
    end

    task automatic step1();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic run, input logic stp, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            btn_run  = run & (c < 10);
            btn_step = stp & (c < 10);
            step1();
        end
        btn_run  = 1'b0;
        btn_step = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        rstn = 1'b0;
        repeat (5) step1();
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_hold_state: got %b expected 00", bus_if.state_o);
        end
        rstn = 1'b1;
        c0 = ce_total;
        repeat (100) step1();
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_state: got %b expected 00", bus_if.state_o);
        end
        n_checks++;
        if (ce_total - c0 !== 0) begin
            n_fail++; $display("FAIL reset_no_ce: got %0d pulses expected 0", ce_total - c0);
        end
        n_checks++;
        if (bus_if.retired_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_retired: got %0d expected 0", bus_if.retired_o);
        end
        n_checks++;
        if (bus_if.bp_hit_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_bp_hit: got %b expected 0", bus_if.bp_hit_o);
        end
        $display("reset: state=%b retired=%0d", bus_if.state_o, bus_if.retired_o);
    endtask

    task automatic test_bounce();
        int c0;
        c0 = ce_total;
        for (int g = 0; g < 6; g++) begin
            btn_run = 1'b1; btn_step = g[0];
            step1();
            btn_run = 1'b0; btn_step = 1'b0;
            step1(); step1();
        end
        repeat (12) step1();
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL bounce_state: got %b expected 00", bus_if.state_o);
        end
        n_checks++;
        if (ce_total - c0 !== 0) begin
            n_fail++; $display("FAIL bounce_no_ce: got %0d pulses expected 0", ce_total - c0);
        end
        $display("bounce: state=%b", bus_if.state_o);
    endtask

    task automatic test_run();
        int c0;
        logic [31:0] r0;
        press(1'b1, 1'b0, 30);
        n_checks++;
        if (bus_if.state_o !== 2'b01) begin
            n_fail++; $display("FAIL run_state: got %b expected 01", bus_if.state_o);
        end
        c0 = ce_total;
        r0 = bus_if.retired_o;
        repeat (40) step1();
        n_checks++;
        if (ce_total - c0 !== 10) begin
            n_fail++; $display("FAIL run_ce_count: got %0d expected 10", ce_total - c0);
        end
        n_checks++;
        if (bus_if.retired_o - r0 !== 32'd10) begin
            n_fail++; $display("FAIL run_retired: got %0d expected 10", bus_if.retired_o - r0);
        end
        n_checks++;
        if (last_gap !== 4) begin
            n_fail++; $display("FAIL run_ce_gap: got %0d expected 4", last_gap);
        end
        n_checks++;
        if (consec_err !== 0) begin
            n_fail++; $display("FAIL run_ce_consecutive: got %0d expected 0", consec_err);
        end
        $display("run: 10 ticks retired %0d", bus_if.retired_o - r0);
        press(1'b1, 1'b0, 30);
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL halt_state: got %b expected 00", bus_if.state_o);
        end
        c0 = ce_total;
        r0 = bus_if.retired_o;
        repeat (40) step1();
        n_checks++;
        if (ce_total - c0 !== 0) begin
            n_fail++; $display("FAIL halt_no_ce: got %0d expected 0", ce_total - c0);
        end
        n_checks++;
        if (bus_if.retired_o !== r0) begin
            n_fail++; $display("FAIL halt_retired: got %0d expected %0d", bus_if.retired_o, r0);
        end
        $display("halt: state=%b", bus_if.state_o);
    endtask

    task automatic test_step();
        int c0;
        logic [31:0] r0;
        logic seen_step;
        c0 = ce_total;
        r0 = bus_if.retired_o;
        seen_step = 1'b0;
        for (int c = 0; c < 40; c++) begin
            btn_step = (c < 10);
            step1();
            if (bus_if.state_o === 2'b10) seen_step = 1'b1;
        end
        btn_step = 1'b0;
        n_checks++;
        if (seen_step !== 1'b1) begin
            n_fail++; $display("FAIL step_state_seen: got %b expected 1", seen_step);
        end
        n_checks++;
        if (ce_total - c0 !== 1) begin
            n_fail++; $display("FAIL step_ce_count: got %0d expected 1", ce_total - c0);
        end
        n_checks++;
        if (bus_if.retired_o - r0 !== 32'd1) begin
            n_fail++; $display("FAIL step_retired: got %0d expected 1", bus_if.retired_o - r0);
        end
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL step_final_state: got %b expected 00", bus_if.state_o);
        end
        $display("step: ce=%0d state=%b", ce_total - c0, bus_if.state_o);
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1, 30);
        n_checks++;
        if (bus_if.state_o !== 2'b01) begin
            n_fail++; $display("FAIL simul_run_wins: got %b expected 01", bus_if.state_o);
        end
        $display("simultaneous: state=%b", bus_if.state_o);
        press(1'b1, 1'b0, 30);
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL simul_halt: got %b expected 00", bus_if.state_o);
        end
    endtask

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    task automatic test_breakpoint();
        int c0;
        logic found;
        logic [31:0] pc_at_ce;
        pc_load = 1'b1;
        step1(); step1();
        pc_load = 1'b0;
        bus_if.bp_en = 1'b1;
        bus_if.bp_addr = 32'h0000_000C;
        c0 = ce_total;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            btn_run = (c < 10);
            step1();
            if (bus_if.state_o === 2'b11) found = 1'b1;
        end
        btn_run = 1'b0;
        repeat (15) step1();
        n_checks++;
        if (bus_if.state_o !== 2'b11) begin
            n_fail++; $display("FAIL bp_state: got %b expected 11", bus_if.state_o);
        end
        n_checks++;
        if (bus_if.bp_hit_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_hit: got %b expected 1", bus_if.bp_hit_o);
        end
        n_checks++;
        if (bus_if.pc !== 32'h0C) begin
            n_fail++; $display("FAIL bp_pc: got %h expected 0000000c", bus_if.pc);
        end
        n_checks++;
        if (ce_total - c0 !== 3) begin
            n_fail++; $display("FAIL bp_ce_count: got %0d expected 3", ce_total - c0);
        end
        $display("breakpoint: state=%b pc=%h", bus_if.state_o, bus_if.pc);
        found = 1'b0;
        pc_at_ce = 32'hFFFF_FFFF;
        for (int c = 0; c < 60 && !found; c++) begin
            btn_run = (c < 10);
            step1();
            if (bus_if.cpu_ce === 1'b1) begin
                found = 1'b1;
                pc_at_ce = bus_if.pc;
            end
        end
        btn_run = 1'b0;
        n_checks++;
        if (pc_at_ce !== 32'h0C) begin
            n_fail++; $display("FAIL bp_resume_pc: got %h expected 0000000c", pc_at_ce);
        end
        step1();
        n_checks++;
        if (bus_if.pc !== 32'h10) begin
            n_fail++; $display("FAIL bp_next_pc: got %h expected 00000010", bus_if.pc);
        end
        repeat (30) step1();
        n_checks++;
        if (bus_if.state_o !== 2'b01) begin
            n_fail++; $display("FAIL bp_no_retrap: got %b expected 01", bus_if.state_o);
        end
        $display("resume: pc=%h state=%b", bus_if.pc, bus_if.state_o);
        press(1'b1, 1'b0, 30);
        bus_if.bp_en = 1'b0;
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL bp_halt: got %b expected 00", bus_if.state_o);
        end
    endtask
`endif

    task automatic test_reset_mid_run();
        logic found;
        press(1'b1, 1'b0, 30);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step1();
            if (bus_if.cpu_ce === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL midrst_ce_timeout: got no ce expected one within 20 clk");
        end
        step1();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL midrst_state: got %b expected 00", bus_if.state_o);
        end
        n_checks++;
        if (bus_if.cpu_ce !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ce: got %b expected 0", bus_if.cpu_ce);
        end
        n_checks++;
        if (bus_if.retired_o !== 32'd0) begin
            n_fail++; $display("FAIL midrst_retired: got %0d expected 0", bus_if.retired_o);
        end
        n_checks++;
        if (bus_if.bp_hit_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_bp_hit: got %b expected 0", bus_if.bp_hit_o);
        end
        step1(); step1();
        rstn = 1'b1;
        repeat (5) step1();
        $display("reset mid-run: state=%b retired=%0d", bus_if.state_o, bus_if.retired_o);
    endtask

    task automatic test_slow();
        int n;
        slow_sel = 1'b1;
        repeat (10) step1();
        press(1'b1, 1'b0, 30);
        n = 0;
        for (int c = 0; c < 80 && n < 3; c++) begin
            step1();
            if (bus_if.cpu_ce === 1'b1) n++;
        end
        n_checks++;
        if (n !== 3) begin
            n_fail++; $display("FAIL slow_ce_count: got %0d expected 3 within 80 clk", n);
        end
        n_checks++;
        if (last_gap !== 16) begin
            n_fail++; $display("FAIL slow_ce_gap: got %0d expected 16", last_gap);
        end
        $display("slow: gap=%0d", last_gap);
        press(1'b1, 1'b0, 30);
        slow_sel = 1'b0;
        n_checks++;
        if (bus_if.state_o !== 2'b00) begin
            n_fail++; $display("FAIL slow_halt: got %b expected 00", bus_if.state_o);
        end
    endtask

    initial begin
        bus_if.bp_en   = 1'b0;
        bus_if.bp_addr = 32'h0;
        test_reset();
        pc_load = 1'b0;
        test_bounce();
        test_run();
        test_step();
        test_simultaneous();
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_reset_mid_run();
        test_slow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cpu_run_ctrl
